// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
//   Scan sequencer and register front-end for an 8-digit seven-segment
//   display mux. A programmable divider steps the digit select, and CPU
//   writes go into shadow registers. The shadows are committed only at a
//   frame boundary (digit 7 -> 0), or on the next cycle while scanning is
//   frozen.
//
//   Optional feature macro: DISP_BLINK_EN
//     defined   - frame-based blink counter; the blank mask is gated by the
//                 blink phase.
//     undefined - no blink logic; LES follows the committed blank mask, and
//                 control bit1 is stored but has no effect.
//
// Parameters
//   SCAN_DIV      clock cycles per digit slot (>= 2)
//   BLINK_FRAMES  frames per blink half-period (>= 1)
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   we          single-cycle write strobe
//   addr        0 hex word, 1 point mask, 2 blank mask, 3 control
//   wdata       write data (addr1/2: [7:0], addr3: [1:0])
//   Scan        digit select to the display mux
//   Hexs        committed hex word
//   point       committed decimal-point mask
//   LES         blank mask after blink gating
//   pending     the shadows hold data that has not been committed
//   frame_done  one-cycle pulse after each commit or frame wrap
module disp_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [2:0]  Scan,
  output logic [31:0] Hexs,
  output logic [7:0]  point,
  output logic [7:0]  LES,
  output logic        pending,
  output logic        frame_done
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [31:0]      sh_hex;
  logic [7:0]       sh_pt;
  logic [7:0]       sh_les;
  logic [1:0]       sh_ctrl;
  logic [7:0]       les_reg;
  logic             scan_en;
  logic             tick;
  logic             frame_end;
  logic             commit;
  logic             unused_bits;

  assign tick      = scan_en && (div == DIV_MAX);
  assign frame_end = tick && (Scan == 3'd7);
  // While frozen, any pending write is committed on the following edge.
  assign commit    = frame_end || (!scan_en && pending);

  always_ff @(posedge clk) begin
    if (rst) begin
      div        <= '0;
      Scan       <= 3'd0;
      Hexs       <= 32'd0;
      point      <= 8'd0;
      les_reg    <= 8'd0;
      scan_en    <= 1'b1;
      sh_hex     <= 32'd0;
      sh_pt      <= 8'd0;
      sh_les     <= 8'd0;
      sh_ctrl    <= 2'b01;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (we) begin
        case (addr)
          2'd0: sh_hex  <= wdata;
          2'd1: sh_pt   <= wdata[7:0];
          2'd2: sh_les  <= wdata[7:0];
          2'd3: sh_ctrl <= wdata[1:0];
          default: ;
        endcase
      end

      // A write in the commit cycle stays pending for the next frame.
      if (we)
        pending <= 1'b1;
      else if (commit)
        pending <= 1'b0;

      frame_done <= commit;

      // The shadows are read before this cycle's write lands.
      if (commit) begin
        Hexs    <= sh_hex;
        point   <= sh_pt;
        les_reg <= sh_les;
        scan_en <= sh_ctrl[0];
      end

      // With scan_en low, div and Scan hold their values. Scanning resumes from them.
      if (scan_en) begin
        if (div == DIV_MAX) begin
          div  <= '0;
          Scan <= Scan + 3'd1;
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

`ifdef DISP_BLINK_EN
  localparam int BF_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BF_W-1:0] BF_MAX = BF_W'(BLINK_FRAMES - 1);

  logic [BF_W-1:0] bf;
  logic            blink_ph;
  logic            blink_en;

  // The blink counter runs from reset even while blink_en is low. Enabling blink therefore picks up the phase already in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      bf       <= '0;
      blink_ph <= 1'b0;
      blink_en <= 1'b0;
    end else begin
      if (commit)
        blink_en <= sh_ctrl[1];
      if (frame_end) begin
        if (bf == BF_MAX) begin
          bf       <= '0;
          blink_ph <= ~blink_ph;
        end else begin
          bf <= bf + 1'b1;
        end
      end
    end
  end

  assign LES         = les_reg | ({8{blink_en & blink_ph}} & ~les_reg);
  assign unused_bits = ^wdata[31:8];
`else
  assign LES         = les_reg;
  assign unused_bits = ^{wdata[31:8], sh_ctrl[1]};
`endif

endmodule
